// File: rtl/sdram_ioctl_loader.sv
// sdram_ioctl_loader: turns HPS ioctl download words into SDRAM write requests and passes the CPU memory port through otherwise.
// Latency: ioctl word to SDRAM_WE is at least 2 cycles; each controller write occupies at least 3 cycles (ISSUE, SETTLE, WAIT).
// Backpressure: IOCTL_WAIT is registered and asserts at FIFO_DEPTH-1 entries, leaving one slot for the HPS response lag.
// Ports: SDRAM_CLK/SDRAM_RST (sync, active-high); IOCTL_* download side; LOADING/LOAD_ERR status;
//        M_* memory-interface requests in / ready out; SDRAM_* controller requests out / ready in.
// Optional: define LOADER_CHECKSUM_EN to add CHECKSUM[15:0], the mod-2^16 sum of all pushed IOCTL_DOUT words.
module sdram_ioctl_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [7:0]  BMP_INDEX  = 8'd2
) (
  input  logic        SDRAM_CLK,
  input  logic        SDRAM_RST,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic [26:0] IOCTL_ADDR,
  input  logic [15:0] IOCTL_DOUT,
  input  logic        IOCTL_WR,
  output logic        IOCTL_WAIT,
  output logic        LOADING,
  output logic        LOAD_ERR,
  input  logic [24:0] M_WADDR,
  input  logic [31:0] M_DIN,
  input  logic [3:0]  M_BE,
  input  logic        M_WE,
  input  logic        M_RD,
  input  logic [24:0] M_RADDR,
  input  logic        M_CLKREF,
  output logic        M_WE_RDY,
  output logic        M_RD_RDY,
  output logic [24:0] SDRAM_WADDR,
  output logic [31:0] SDRAM_DIN,
  output logic [3:0]  SDRAM_BE,
  output logic        SDRAM_WE,
  output logic        SDRAM_RD,
  output logic [24:0] SDRAM_RADDR,
  output logic        SDRAM_CLKREF,
  input  logic        SDRAM_WE_RDY,
  input  logic        SDRAM_RD_RDY
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] CHECKSUM
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [24:0] ROM_BASE  = 25'h000_0000;
  localparam logic [26:0] ROM_LIMIT = 27'h010_0000;
  localparam logic [24:0] BMP_BASE  = 25'h100_0000;
  localparam logic [26:0] BMP_LIMIT = 27'h080_0000;

  typedef struct packed {
    logic [24:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT} state_t;

  state_t         state_q;
  logic           we_q;
  logic           dl_q;
  logic [7:0]     idx_q;
  logic           loading_q, loading_d;
  logic           err_q;
  logic           wait_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  entry_t         mem_q [FIFO_DEPTH];

  logic           start;
  logic [7:0]     idx;
  logic           idx_ok;
  logic [24:0]    base;
  logic [26:0]    limit;
  logic           wr_req, push, pop, drop;
  entry_t         new_entry, head;

  // A write on the very cycle of the rising edge already belongs to the new session.
  assign start = IOCTL_DOWNLOAD & ~dl_q;
  assign idx   = start ? IOCTL_INDEX : idx_q;

  always_comb begin
    idx_ok = 1'b0;
    base   = '0;
    limit  = '0;
    if (idx == ROM_INDEX) begin
      idx_ok = 1'b1;
      base   = ROM_BASE;
      limit  = ROM_LIMIT;
    end else if (idx == BMP_INDEX) begin
      idx_ok = 1'b1;
      base   = BMP_BASE;
      limit  = BMP_LIMIT;
    end
  end

  assign wr_req  = IOCTL_WR & IOCTL_DOWNLOAD;
  assign push    = wr_req & idx_ok & (IOCTL_ADDR < limit) & (count_q != CW'(FIFO_DEPTH));
  assign drop    = wr_req & ~push;
  assign pop     = (state_q == S_WAIT) & SDRAM_WE_RDY;
  assign count_d = count_q + CW'(push) - CW'(pop);

  assign new_entry.addr = base + IOCTL_ADDR[24:0];
  assign new_entry.din  = {2{IOCTL_DOUT}};
  assign new_entry.be   = IOCTL_ADDR[1] ? 4'b1100 : 4'b0011;
  assign head           = mem_q[rd_ptr_q];

  // Start wins over the drain-complete condition so a restart during drain keeps ownership.
  always_comb begin
    loading_d = loading_q;
    if (start)
      loading_d = 1'b1;
    else if (!IOCTL_DOWNLOAD && count_q == '0 && state_q == S_IDLE)
      loading_d = 1'b0;
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge SDRAM_CLK) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge SDRAM_CLK) begin
    if (SDRAM_RST) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      dl_q      <= 1'b0;
      idx_q     <= '0;
      loading_q <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      dl_q      <= IOCTL_DOWNLOAD;
      loading_q <= loading_d;
      count_q   <= count_d;
      wait_q    <= (count_d >= CW'(FIFO_DEPTH - 1));
      if (start) idx_q <= IOCTL_INDEX;
      if (drop)
        err_q <= 1'b1;
      else if (start)
        err_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case (state_q)
        S_IDLE: begin
          if (count_q != '0 && SDRAM_WE_RDY) begin
            state_q <= S_ISSUE;
            we_q    <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_SETTLE;
          we_q    <= 1'b0;
        end
        // Controller ready may still reflect the previous request here.
        S_SETTLE: state_q <= S_WAIT;
        S_WAIT:   if (SDRAM_WE_RDY) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign IOCTL_WAIT = wait_q;
  assign LOADING    = loading_q;
  assign LOAD_ERR   = err_q;

  assign SDRAM_WADDR  = loading_q ? head.addr : M_WADDR;
  assign SDRAM_DIN    = loading_q ? head.din  : M_DIN;
  assign SDRAM_BE     = loading_q ? head.be   : M_BE;
  assign SDRAM_WE     = loading_q ? we_q      : M_WE;
  assign SDRAM_RD     = loading_q ? 1'b0      : M_RD;
  assign SDRAM_RADDR  = M_RADDR;
  assign SDRAM_CLKREF = loading_q ? 1'b1      : M_CLKREF;
  assign M_WE_RDY     = loading_q ? 1'b0      : SDRAM_WE_RDY;
  assign M_RD_RDY     = loading_q ? 1'b0      : SDRAM_RD_RDY;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge SDRAM_CLK) begin
    if (SDRAM_RST)
      sum_q <= '0;
    else if (start)
      sum_q <= push ? IOCTL_DOUT : 16'd0;
    else if (push)
      sum_q <= sum_q + IOCTL_DOUT;
  end

  assign CHECKSUM = sum_q;
`endif

endmodule

// File: doc/sdram_ioctl_loader.md
Name: sdram_ioctl_loader

Overview:
- Sits between the HPS ioctl download port, the CPU-side memory interface and the shared SDRAM controller port, all in the SDRAM_CLK domain.
- During a download it converts 16-bit ioctl words into SDRAM write requests at the ROM or BMP region base. Writes are buffered in a small FIFO and paced with IOCTL_WAIT.
- Outside a download it passes the memory-interface request signals straight through to the controller.
- LOADING holds the CPU in reset while the loader owns the port.

Parameters:
- FIFO_DEPTH, 4: number of buffered write entries; power of 2, minimum 2.
- ROM_INDEX, 8'd0: IOCTL_INDEX value that selects the ROM region (base 25'h000_0000, limit 1 MiB).
- BMP_INDEX, 8'd2: IOCTL_INDEX value that selects the BMP region (base 25'h100_0000, limit 8 MiB).

Ports:
- SDRAM_CLK  in  1  sole clock.
- SDRAM_RST  in  1  synchronous, active-high reset.
- IOCTL_DOWNLOAD  in  1  download session active.
- IOCTL_INDEX  in  8  target image selector.
- IOCTL_ADDR  in  27  byte address within the image; bit 0 is always 0.
- IOCTL_DOUT  in  16  data word.
- IOCTL_WR  in  1  one-cycle write strobe.
- IOCTL_WAIT  out  1  back-pressure to the HPS.
- LOADING  out  1  loader owns the SDRAM port; CPU is held in reset.
- LOAD_ERR  out  1  sticky flag: a write fell outside the region limit or used an unknown index.
- M_WADDR/M_DIN/M_BE/M_WE/M_RD/M_RADDR/M_CLKREF  in  25/32/4/1/1/25/1  memory-interface request side.
- M_WE_RDY/M_RD_RDY  out  1/1  ready signals returned to the memory interface.
- SDRAM_WADDR/SDRAM_DIN/SDRAM_BE/SDRAM_WE/SDRAM_RD/SDRAM_RADDR/SDRAM_CLKREF  out  25/32/4/1/1/25/1  controller request side.
- SDRAM_WE_RDY/SDRAM_RD_RDY  in  1/1  controller ready signals.

Behaviour:
- Clock and reset: one clock (SDRAM_CLK); reset (SDRAM_RST) is synchronous and active-high.
- Reset state: FSM in IDLE, FIFO empty, LOADING=0, LOAD_ERR=0, IOCTL_WAIT=0, SDRAM_WE=0.
- Session start (rising edge of IOCTL_DOWNLOAD):
  - LOADING=1 and LOAD_ERR clears on the next cycle.
  - The index is latched once for the session; later IOCTL_INDEX changes are ignored.
- Write capture on IOCTL_WR:
  - Address = base + IOCTL_ADDR[24:0].
  - DIN = {2{IOCTL_DOUT}}.
  - BE = 4'b1100 if IOCTL_ADDR[1], else 4'b0011.
  - The entry is pushed into the FIFO.
- Dropped writes:
  - Writes whose IOCTL_ADDR is at or beyond the region limit, or whose index is unknown, are dropped and set LOAD_ERR.
  - A write arriving with the FIFO full is dropped and sets LOAD_ERR; this is a protocol violation.
- IOCTL_WAIT is registered: 1 when FIFO count ≥ FIFO_DEPTH−1, so the one-cycle HPS response lag cannot overflow the FIFO.
- Write FSM:
  - IDLE: FIFO non-empty and SDRAM_WE_RDY=1 → ISSUE.
  - ISSUE: SDRAM_WE=1 for exactly one cycle with the head entry → SETTLE.
  - SETTLE: one cycle; SDRAM_WE_RDY is ignored → WAIT.
  - WAIT: SDRAM_WE_RDY=1 → pop the entry → IDLE.
  - Minimum of 3 cycles per write.
  - A simultaneous push and pop keeps the count unchanged.
- Session end: when IOCTL_DOWNLOAD falls, the FIFO drains. LOADING falls on the first cycle with FIFO empty and FSM in IDLE.
- Restart during drain: a new rising edge of IOCTL_DOWNLOAD while draining keeps LOADING=1. It latches the new index; already-queued entries keep their original addresses.
- Muxing while LOADING=1:
  - SDRAM_RD=0, SDRAM_CLKREF=1.
  - Write-side outputs are driven from the FIFO head.
  - M_WE_RDY=0 and M_RD_RDY=0.
- Muxing while LOADING=0:
  - All M_* requests pass combinationally to SDRAM_*.
  - SDRAM_*_RDY passes to M_*_RDY.
- Reset mid-session: the FIFO is flushed and LOADING=0 immediately. A controller write already in flight is abandoned without waiting.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro: adds output CHECKSUM[15:0].
  - Modulo-2^16 sum of every IOCTL_DOUT word actually pushed into the FIFO.
  - Cleared on each session start and on reset.
  - Holds its value after the session ends.
- Without the macro: the port and the adder are absent; behaviour is otherwise identical.

Test Plan:
- ROM load:
  - Stimulus: DOWNLOAD=1, INDEX=0, four writes at ADDR 0,2,4,6 with DOUT 1111,2222,3333,4444; controller drops WE_RDY for 2 cycles per write.
  - Response: four SDRAM_WE pulses with WADDR 0,2,4,6, BE 0011,1100,0011,1100, DIN 11111111 etc.; LOADING falls after the last acknowledgement.
- BMP offset:
  - Stimulus: INDEX=2, ADDR=27'h10.
  - Response: WADDR=25'h100_0010.
- Back-pressure:
  - Stimulus: WE_RDY held low; 4 back-to-back IOCTL_WR.
  - Response: IOCTL_WAIT=1 after the 3rd push; no entry lost; no LOAD_ERR.
- Limit violation:
  - Stimulus: INDEX=0, ADDR=27'h10_0000.
  - Response: no SDRAM_WE; LOAD_ERR=1; LOAD_ERR clears at the next session start.
- Pass-through:
  - Stimulus: LOADING=0, M_RD=1, M_RADDR=25'h010_0040.
  - Response: SDRAM_RD=1 with the same address in the same cycle.
  - Stimulus: the same request during LOADING.
  - Response: SDRAM_RD=0 and M_RD_RDY=0.
- Reset mid-session:
  - Stimulus: SDRAM_RST asserted with 3 entries queued.
  - Response: next cycle FIFO empty, LOADING=0, SDRAM_WE=0; CHECKSUM=0 when LOADER_CHECKSUM_EN is defined.
